// File: rtl/bus_gate_arbiter.sv
// bus_gate_arbiter: registered N-source gate-onto-bus selector with fixed-priority or round-robin
// arbitration, grant locking and conflict detection. Define BUS_ARB_CONFLICT_CNT_EN for Conflict_count.
module bus_gate_arbiter #(
    parameter int WIDTH     = 16,
    parameter int N         = 4,
    parameter bit RR_MODE   = 1'b0,
    parameter bit HOLD_LAST = 1'b1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [N-1:0]       Gate,
    input  logic [N*WIDTH-1:0] Data_in,
    input  logic               Lock,
    input  logic               Clear_conflict,
    output logic [WIDTH-1:0]   Bus_out,
    output logic [N-1:0]       Grant,
    output logic               Bus_valid,
    output logic               Conflict,
`ifdef BUS_ARB_CONFLICT_CNT_EN
    output logic               Conflict_sticky,
    output logic [7:0]         Conflict_count
`else
    output logic               Conflict_sticky
`endif
);
    localparam int IW = $clog2(N);

    logic [N-1:0][WIDTH-1:0] src;
    logic [IW-1:0]           ptr;
    logic [IW-1:0]           held_idx;
    logic [IW-1:0]           win_idx;
    logic [IW-1:0]           cand;
    logic                    lock_hit;
    logic                    any_gate;
    logic                    multi;

    assign src      = Data_in;
    assign any_gate = |Gate;
    assign multi    = $countones(Gate) > 1;
    // Grant is one-hot, so any overlap with Gate means the holder still requests.
    assign lock_hit = Lock && |(Grant & Gate);

    always_comb begin
        held_idx = '0;
        for (int i = 0; i < N; i++)
            if (Grant[i]) held_idx = IW'(i);
    end

    // Loops run from the far end so the last hit is the highest-priority candidate.
    always_comb begin
        win_idx = '0;
        cand    = '0;
        if (lock_hit) begin
            win_idx = held_idx;
        end else if (!RR_MODE) begin
            for (int i = N - 1; i >= 0; i--)
                if (Gate[i]) win_idx = IW'(i);
        end else begin
            for (int k = N; k >= 1; k--) begin
                cand = IW'((int'(ptr) + k) % N);
                if (Gate[cand]) win_idx = cand;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Bus_out         <= '0;
            Grant           <= '0;
            Bus_valid       <= 1'b0;
            Conflict        <= 1'b0;
            Conflict_sticky <= 1'b0;
            ptr             <= IW'(N - 1);
        end else begin
            Conflict        <= multi;
            Conflict_sticky <= multi | (Conflict_sticky & ~Clear_conflict);
            if (any_gate) begin
                Bus_out   <= src[win_idx];
                Grant     <= {{(N-1){1'b0}}, 1'b1} << win_idx;
                Bus_valid <= 1'b1;
                if (!lock_hit) ptr <= win_idx;
            end else begin
                Grant     <= '0;
                Bus_valid <= 1'b0;
                if (!HOLD_LAST) Bus_out <= '0;
            end
        end
    end

`ifdef BUS_ARB_CONFLICT_CNT_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            Conflict_count <= '0;
        else if (Clear_conflict)
            Conflict_count <= {7'd0, multi};
        else if (multi && Conflict_count != 8'hFF)
            Conflict_count <= Conflict_count + 8'd1;
    end
`endif
endmodule
